candy_wb_buffered: RTL
======================

// Module: candy_wb_buffered
// PURPOSE
//  Parametrised writeback stage. Accepts one result per handshake from EX/MEM.
//  Register results drive a one-cycle register-file write pulse. SRAM stores queue in
//  an N-entry in-order store buffer, drained to SRAM through a req/ack handshake.
//  Sits between candy_mem and the register file / data SRAM port.
// PARAMETERS
//  DATA_W      32  result / SRAM / register data width
//  SRAM_AW     16  SRAM address width
//  REG_AW      5   register address width
//  SB_DEPTH    4   store-buffer entries; power of two, >=2
// PORTS
//  clk               in   1        clock, rising edge
//  rst               in   1        asynchronous, active-low reset
//  in_valid          in   1        result valid
//  in_ready          out  1        stage can accept a result
//  is_mem            in   1        1 = SRAM store, 0 = register write
//  result            in   DATA_W   data to write
//  sram_result_addr  in   SRAM_AW  store address (used when is_mem=1)
//  reg_addr          in   REG_AW   destination register (used when is_mem=0)
//  sram_write_enable out  1        store request, head of buffer valid
//  sram_waddr        out  SRAM_AW  head entry address
//  sram_wdata        out  DATA_W   head entry data
//  sram_ack          in   1        SRAM accepted current request
//  reg_write_enable  out  1        register-file write strobe
//  reg_waddr         out  REG_AW   register write address
//  reg_wdata         out  DATA_W   register write data
//  sb_count          out  clog2(SB_DEPTH)+1  occupied store-buffer entries
//  sb_empty          out  1        store buffer drained (fence/idle indicator)
// BEHAVIOUR
//  - Reset (rst=0, async): count, rd/wr pointers, reg_write_enable = 0.
//    reg_waddr and reg_wdata = 0. Buffer storage is not reset. sb_empty = 1.
//  - fire_in = in_valid & in_ready. in_ready = (count != SB_DEPTH).
//    It is registered-state only, with no combinational path from in_valid or sram_ack.
//    A full buffer also stalls register writes, which keeps writeback in order.
//  - Register path (fire_in & !is_mem): next cycle reg_write_enable=1,
//    reg_waddr=reg_addr, reg_wdata=result. Latency 1.
//    - reg_write_enable drops to 0 in any cycle without such a fire.
//    - reg_waddr and reg_wdata hold their last value when reg_write_enable=0.
//    - reg_addr==0: the write is dropped. The handshake still completes, but no
//      strobe is raised.
//  - Store path (fire_in & is_mem): {sram_result_addr,result} is written at wr_ptr.
//    wr_ptr and count are incremented.
//  - Drain: sram_write_enable = (count != 0). sram_waddr and sram_wdata are driven
//    combinationally from the entry at rd_ptr.
//    - sram_write_enable & sram_ack: rd_ptr++ and count--.
//    - Request and payload stay stable while sram_ack=0.
//    - sram_ack while sram_write_enable=0 is ignored.
//  - Earliest drain: a store is visible on the SRAM port the cycle after it is accepted.
//  - Push and pop in the same cycle: count is unchanged and both pointers advance.
//    Not possible when full, because in_ready=0.
//  - Pointers wrap modulo SB_DEPTH. count is the full/empty authority.
//  - Stores reach SRAM in acceptance order. Relative order of a register write and
//    an earlier store is not enforced.
//  - sb_empty = (count == 0), combinational from state.
//  - Reset mid-drain: pending stores are discarded. Outputs go to reset values
//    immediately.
// CONFIGURATION
//  CANDY_WB_FWD_EN defined: adds ports
//    ld_addr  in   SRAM_AW
//    ld_hit   out  1
//    ld_data  out  DATA_W
//   - Combinational search of valid buffer entries. ld_hit=1 if any entry matches
//     ld_addr.
//   - ld_data comes from the youngest matching entry, which gives correct
//     store-to-load forwarding.
//   - Entries are valid from the cycle after push until the cycle of pop. No hit
//     occurs in the acceptance cycle.
//   - ld_data = 0 when ld_hit = 0.
//  CANDY_WB_FWD_EN undefined: the ports are absent and loads must wait for sb_empty.
// TESTING
//  1 Reset: rst=0 mid-run -> all outputs 0, sb_empty=1, in_ready=1, pending stores
//    lost.
//  2 Reg write: is_mem=0, reg_addr=5, result=0xDEADBEEF -> next cycle
//    reg_write_enable=1, reg_waddr=5, reg_wdata=0xDEADBEEF; following cycle enable=0.
//  3 R0 drop: is_mem=0, reg_addr=0, result=0x1234 -> in_ready=1, reg_write_enable
//    stays 0.
//  4 Fill and backpressure: sram_ack=0, push 4 stores (addr 0x10..0x13,
//    data 0xA0..0xA3) -> sb_count=4, in_ready=0, sram_waddr=0x10 held.
//    Then ack 4 cycles -> 0x10..0x13 in order, sb_empty=1.
//  5 Simultaneous push and pop: count=2, ack=1 and a new store in the same cycle ->
//    count stays 2, pointers wrap correctly past entry 3.
//  6 Forwarding (FWD_EN): stores 0x20<-0x1, 0x20<-0x2 buffered, ld_addr=0x20 ->
//    ld_hit=1, ld_data=0x2. After both acks -> ld_hit=0.

Source files
------------

// File: rtl/candy_wb_buffered_if.sv
// Writeback-stage bundle: result intake, SRAM store drain, register-file write, buffer status.
// With CANDY_WB_FWD_EN defined, it also carries the store-to-load forwarding lookup signals.
interface candy_wb_buffered_if #(
    parameter int DATA_W   = 32,
    parameter int SRAM_AW  = 16,
    parameter int REG_AW   = 5,
    parameter int SB_DEPTH = 4
);
    localparam int CNT_W = $clog2(SB_DEPTH) + 1;

    logic               in_valid;
    logic               in_ready;
    logic               is_mem;
    logic [DATA_W-1:0]  result;
    logic [SRAM_AW-1:0] sram_result_addr;
    logic [REG_AW-1:0]  reg_addr;

    logic               sram_write_enable;
    logic [SRAM_AW-1:0] sram_waddr;
    logic [DATA_W-1:0]  sram_wdata;
    logic               sram_ack;

    logic               reg_write_enable;
    logic [REG_AW-1:0]  reg_waddr;
    logic [DATA_W-1:0]  reg_wdata;

    logic [CNT_W-1:0]   sb_count;
    logic               sb_empty;

`ifdef CANDY_WB_FWD_EN
    logic [SRAM_AW-1:0] ld_addr;
    logic               ld_hit;
    logic [DATA_W-1:0]  ld_data;

    modport slave (
        input  in_valid, is_mem, result, sram_result_addr, reg_addr, sram_ack, ld_addr,
        output in_ready, sram_write_enable, sram_waddr, sram_wdata,
               reg_write_enable, reg_waddr, reg_wdata, sb_count, sb_empty, ld_hit, ld_data
    );
    modport master (
        output in_valid, is_mem, result, sram_result_addr, reg_addr, sram_ack, ld_addr,
        input  in_ready, sram_write_enable, sram_waddr, sram_wdata,
               reg_write_enable, reg_waddr, reg_wdata, sb_count, sb_empty, ld_hit, ld_data
    );
`else
    modport slave (
        input  in_valid, is_mem, result, sram_result_addr, reg_addr, sram_ack,
        output in_ready, sram_write_enable, sram_waddr, sram_wdata,
               reg_write_enable, reg_waddr, reg_wdata, sb_count, sb_empty
    );
    modport master (
        output in_valid, is_mem, result, sram_result_addr, reg_addr, sram_ack,
        input  in_ready, sram_write_enable, sram_waddr, sram_wdata,
               reg_write_enable, reg_waddr, reg_wdata, sb_count, sb_empty
    );
`endif
endinterface

// File: rtl/candy_wb_buffered.sv
// Writeback stage: register writes as 1-cycle strobes, SRAM stores via an in-order store buffer.
// Latency: register write 1 cycle; a store appears on the SRAM port 1 cycle after acceptance.
// Backpressure: in_ready drops when the buffer is full, which stalls all results; the drain waits on sram_ack.
// Optional store-to-load forwarding is enabled with CANDY_WB_FWD_EN.
module candy_wb_buffered #(
    parameter int DATA_W   = 32,
    parameter int SRAM_AW  = 16,
    parameter int REG_AW   = 5,
    parameter int SB_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    candy_wb_buffered_if.slave   bus
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               reg_we_q, reg_we_d;
    logic [REG_AW-1:0]  reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0]  reg_wdata_q, reg_wdata_d;

    // Storage is not reset; count_q alone decides which entries are live.
    logic [SRAM_AW-1:0] sb_addr_mem [SB_DEPTH];
    logic [DATA_W-1:0]  sb_data_mem [SB_DEPTH];

    logic in_ready_c;
    logic fire_in;
    logic push;
    logic pop;
    logic sb_nonempty;

    assign sb_nonempty = (count_q != '0);
    assign in_ready_c  = (count_q != CNT_W'(SB_DEPTH));
    assign fire_in     = bus.in_valid & in_ready_c;
    assign push        = fire_in & bus.is_mem;
    assign pop         = sb_nonempty & bus.sram_ack;

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Writes to r0 complete the handshake but never strobe the register file.
        if (fire_in && !bus.is_mem && (bus.reg_addr != '0)) begin
            reg_we_d    = 1'b1;
            reg_waddr_d = bus.reg_addr;
            reg_wdata_d = bus.result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr_mem[wr_ptr_q] <= bus.sram_result_addr;
            sb_data_mem[wr_ptr_q] <= bus.result;
        end
    end

    assign bus.in_ready          = in_ready_c;
    assign bus.sram_write_enable = sb_nonempty;
    assign bus.sram_waddr        = sb_addr_mem[rd_ptr_q];
    assign bus.sram_wdata        = sb_data_mem[rd_ptr_q];
    assign bus.reg_write_enable  = reg_we_q;
    assign bus.reg_waddr         = reg_waddr_q;
    assign bus.reg_wdata         = reg_wdata_q;
    assign bus.sb_count          = count_q;
    assign bus.sb_empty          = ~sb_nonempty;

`ifdef CANDY_WB_FWD_EN
    logic              ld_hit_c;
    logic [DATA_W-1:0] ld_data_c;
    logic [PTR_W-1:0]  fwd_idx;

    // Walk oldest to youngest so the youngest matching store wins.
    always_comb begin
        ld_hit_c  = 1'b0;
        ld_data_c = '0;
        fwd_idx   = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (sb_addr_mem[fwd_idx] == bus.ld_addr)) begin
                ld_hit_c  = 1'b1;
                ld_data_c = sb_data_mem[fwd_idx];
            end
        end
    end

    assign bus.ld_hit  = ld_hit_c;
    assign bus.ld_data = ld_data_c;
`endif
endmodule
